// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous modulo-MODULUS up/down counter. It produces the
// per-bit J/K excitation that a downstream bank of JK flip-flops uses to reach
// the next count. The counter also keeps its own reference copy of the count
// (q), a terminal-count flag, a one-shot done flag and a sticky load-error flag.
//
// Build option: define JK_MOD_COUNTER_DOWN_EN to honour the 'up' port.
// When it is left undefined, the counter is up-only and 'up' is ignored.
module jk_mod_counter #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 10,
   parameter int ONE_SHOT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k,
   output logic             tc,
   output logic             done,
   output logic             load_err
);

   // MODULUS may equal 2**WIDTH, so the range check runs one bit wider than q.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] n;
   logic [WIDTH-1:0] inc_val;
   logic             load_bad;
   logic             at_term;
   logic             step;

`ifndef JK_MOD_COUNTER_DOWN_EN
   // Direction input is deliberately unused in the up-only build.
   logic unused_up;
   assign unused_up = up;
`endif

   // Range check, terminal detection, next count and next FSM state.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      load_bad   = ({1'b0, load_val} >= MOD_EXT);
      step       = en && (state == RUN);
      inc_val    = (q == MAX_VAL) ? '0 : q + ONE;
      n          = q;
      state_next = state;

`ifdef JK_MOD_COUNTER_DOWN_EN
      at_term = up ? (q == MAX_VAL) : (q == '0);
`else
      at_term = (q == MAX_VAL);
`endif

      tc = step && !load && at_term;

      if (load) begin
         n = load_bad ? MAX_VAL : load_val;
      end else if (step) begin
`ifdef JK_MOD_COUNTER_DOWN_EN
         if (up) n = inc_val;
         else    n = (q == '0) ? MAX_VAL : q - ONE;
`else
         n = inc_val;
`endif
      end

      if (load) begin
         state_next = RUN;
      end else if ((ONE_SHOT != 0) && tc) begin
         state_next = HALT;
      end
   end

   // JK excitation toward n; forced quiet while reset is held.
   always_comb begin
      j = '0;
      k = '0;
      if (!reset) begin
         j = n & ~q;
         k = ~n & q;
      end
   end

   // Reference register updated via the JK characteristic equation, plus flags.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q        <= '0;
         state    <= RUN;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= (j & ~q) | (~k & q);
         state    <= state_next;
         done     <= (state_next == HALT);
         load_err <= load_err | (load & load_bad);
      end
   end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Testbench for jk_mod_counter. It instantiates a free-running unit and a
// one-shot unit. The stimulus pushes hand-computed expectations into a
// scoreboard queue, and a monitor pops and compares them on the falling edge.
module tb_jk_mod_counter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;

   logic         en0, up0, load0;
   logic [W-1:0] lv0, q0, j0, k0;
   logic         tc0, done0, le0;

   logic         en1, up1, load1;
   logic [W-1:0] lv1, q1, j1, k1;
   logic         tc1, done1, le1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      int          unit;
      logic [14:0] val;   // {q, j, k, tc, done, load_err}
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] cur [2];

   // External JK bank driven only by j0/k0, used in the random phase.
   logic [W-1:0] bank;
   bit           rnd_on = 1'b0;
   int           jk_viol = 0;
   int           bank_viol = 0;

   jk_mod_counter #(.WIDTH(W), .MODULUS(10), .ONE_SHOT(0)) dut (
      .clk(clk), .reset(reset), .en(en0), .up(up0), .load(load0),
      .load_val(lv0), .q(q0), .j(j0), .k(k0), .tc(tc0), .done(done0),
      .load_err(le0)
   );

   jk_mod_counter #(.WIDTH(W), .MODULUS(10), .ONE_SHOT(1)) dut_os (
      .clk(clk), .reset(reset), .en(en1), .up(up1), .load(load1),
      .load_val(lv1), .q(q1), .j(j1), .k(k1), .tc(tc1), .done(done1),
      .load_err(le1)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // JK flip-flop bank: 01 clear, 10 set, 11 toggle, 00 hold.
   always @(posedge clk or posedge reset) begin : jk_bank
      logic [W-1:0] nb;
      if (reset) begin
         bank <= '0;
      end else begin
         nb = bank;
         for (int i = 0; i < W; i++) begin
            case ({j0[i], k0[i]})
               2'b01:   nb[i] = 1'b0;
               2'b10:   nb[i] = 1'b1;
               2'b11:   nb[i] = ~bank[i];
               default: nb[i] = bank[i];
            endcase
         end
         bank <= nb;
      end
   end

   // Monitor: compare each queued expectation against the selected unit.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [14:0] act;
         e = sb.pop_front();
         act = (e.unit == 0) ? {q0, j0, k0, tc0, done0, le0}
                             : {q1, j1, k1, tc1, done1, le1};
         check(e.name, 32'(act), 32'(e.val));
      end
      if (rnd_on) begin
         if ((j0 & k0) != '0) jk_viol++;
         if (bank !== q0)     bank_viol++;
      end
   end

   // Drive one cycle on unit u and queue the expected outputs for that cycle.
   // n is the hand-computed next count; j/k follow from n and the current q.
   task automatic drive(input string name, input int u, input logic e, input logic d,
                        input logic ld, input logic [W-1:0] lv, input logic [W-1:0] n,
                        input logic t, input logic dn, input logic le);
      exp_t x;
      logic [W-1:0] qv;
      @(posedge clk);
      #1;
      en0 = 1'b0; up0 = 1'b0; load0 = 1'b0; lv0 = '0;
      en1 = 1'b0; up1 = 1'b0; load1 = 1'b0; lv1 = '0;
      if (u == 0) begin
         en0 = e; up0 = d; load0 = ld; lv0 = lv;
      end else begin
         en1 = e; up1 = d; load1 = ld; lv1 = lv;
      end
      qv     = cur[u];
      x.name = name;
      x.unit = u;
      x.val  = {qv, n & ~qv, ~n & qv, t, dn, le};
      sb.push_back(x);
      cur[u] = n;
   endtask

   initial begin
      reset = 1'b1;
      en0 = 0; up0 = 0; load0 = 0; lv0 = '0;
      en1 = 0; up1 = 0; load1 = 0; lv1 = '0;
      cur[0] = '0; cur[1] = '0;
      repeat (2) @(negedge clk);
      check("reset_q",    32'(q0), 0);
      check("reset_jk",   32'({j0, k0}), 0);
      check("reset_flags", 32'({tc0, done0, le0, done1, le1}), 0);
      reset = 1'b0;

      // One-shot unit: load 7, count up to the wrap, halt, reload.
      drive("os_load7",   1, 0, 1, 1, 4'd7, 4'd7, 0, 0, 0);
      drive("os_q7",      1, 1, 1, 0, 4'd0, 4'd8, 0, 0, 0);
      drive("os_q8",      1, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0);
      drive("os_wrap",    1, 1, 1, 0, 4'd0, 4'd0, 1, 0, 0);
      drive("os_halt",    1, 1, 1, 0, 4'd0, 4'd0, 0, 1, 0);
      drive("os_halt_dn", 1, 1, 0, 0, 4'd0, 4'd0, 0, 1, 0);
      drive("os_reload",  1, 1, 1, 1, 4'd2, 4'd2, 0, 1, 0);
      drive("os_resume",  1, 1, 1, 0, 4'd0, 4'd3, 0, 0, 0);
      drive("os_load9",   1, 0, 1, 1, 4'd9, 4'd9, 0, 0, 0);
      drive("os_ld_tc",   1, 1, 1, 1, 4'd4, 4'd4, 0, 0, 0);
      drive("os_no_halt", 1, 1, 1, 0, 4'd0, 4'd5, 0, 0, 0);

      // Free-running unit: count 0..9 and wrap.
      for (int c = 0; c < 10; c++) begin
         logic [W-1:0] nn;
         nn = (c == 9) ? 4'd0 : 4'(c + 1);
         drive("up_count", 0, 1, 1, 0, 4'd0, nn, (c == 9), 0, 0);
      end
      drive("hold_0", 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 0);

`ifdef JK_MOD_COUNTER_DOWN_EN
      drive("down_wrap", 0, 1, 0, 0, 4'd0, 4'd9, 1, 0, 0);
      drive("down_9",    0, 1, 0, 0, 4'd0, 4'd8, 0, 0, 0);
      drive("down_8",    0, 1, 0, 0, 4'd0, 4'd7, 0, 0, 0);
      drive("down_7",    0, 1, 0, 0, 4'd0, 4'd6, 0, 0, 0);
`else
      drive("uponly_0",  0, 1, 0, 0, 4'd0, 4'd1, 0, 0, 0);
      drive("uponly_1",  0, 1, 0, 0, 4'd0, 4'd2, 0, 0, 0);
      drive("uponly_2",  0, 1, 0, 0, 4'd0, 4'd3, 0, 0, 0);
      drive("uponly_3",  0, 1, 0, 0, 4'd0, 4'd4, 0, 0, 0);
`endif

      // Load priority, range boundary and sticky error.
      drive("load_over_en", 0, 1, 1, 1, 4'd5,  4'd5, 0, 0, 0);
      drive("hold_5",       0, 0, 1, 0, 4'd0,  4'd5, 0, 0, 0);
      drive("load_9_ok",    0, 0, 1, 1, 4'd9,  4'd9, 0, 0, 0);
      drive("no_err_9",     0, 0, 1, 0, 4'd0,  4'd9, 0, 0, 0);
      drive("load_12",      0, 0, 1, 1, 4'd12, 4'd9, 0, 0, 0);
      drive("err_sticky",   0, 0, 1, 1, 4'd3,  4'd3, 0, 0, 1);
      drive("count_err",    0, 1, 1, 0, 4'd0,  4'd4, 0, 0, 1);
      drive("load_9_again", 0, 0, 0, 1, 4'd9,  4'd9, 0, 0, 1);
      drive("load_at_tc",   0, 1, 1, 1, 4'd2,  4'd2, 0, 0, 1);
      drive("after_ld_tc",  0, 1, 1, 0, 4'd0,  4'd3, 0, 0, 1);

      // Put the one-shot unit back into HALT before the reset test.
      drive("os_load8",   1, 0, 1, 1, 4'd8, 4'd8, 0, 0, 0);
      drive("os_q8b",     1, 1, 1, 0, 4'd0, 4'd9, 0, 0, 0);
      drive("os_wrap_b",  1, 1, 1, 0, 4'd0, 4'd0, 1, 0, 0);
      drive("os_halt_b",  1, 0, 1, 0, 4'd0, 4'd0, 0, 1, 0);

      // Asynchronous reset in mid-cycle with q = 7.
      drive("load_7", 0, 0, 1, 1, 4'd7, 4'd7, 0, 0, 1);
      @(posedge clk);
      #2;
      en0 = 1'b1; up0 = 1'b1; load0 = 1'b0;
      #1;
      check("pre_reset_q7", 32'(q0), 7);
      reset = 1'b1;
      #1;
      check("async_rst_q",     32'(q0), 0);
      check("async_rst_jk",    32'({j0, k0}), 0);
      check("async_rst_done",  32'(done1), 0);
      check("async_rst_lderr", 32'(le0), 0);
      check("async_rst_q_os",  32'(q1), 0);
      @(negedge clk);
      reset = 1'b0;
      en0 = 1'b0;
      cur[0] = '0; cur[1] = '0;
      drive("resume_first", 0, 1, 1, 0, 4'd0, 4'd1, 0, 0, 0);
      drive("resume_hold",  0, 0, 1, 0, 4'd0, 4'd1, 0, 0, 0);

      // Randomized traffic with the JK bank following j0/k0.
      @(posedge clk);
      #1;
      rnd_on = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         en0   = ($urandom_range(0, 3) != 0);
         up0   = 1'($urandom_range(0, 1));
         load0 = ($urandom_range(0, 7) == 0);
         lv0   = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      rnd_on = 1'b0;
      check("jk_exclusive",  32'(jk_viol), 0);
      check("jk_bank_track", 32'(bank_viol), 0);

      for (int c = 0; c < 10 && sb.size() != 0; c++) @(negedge clk);
      check("scoreboard_drain", 32'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
